// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner issuing one imem read at a time and buffering returned words for decode
// Redirects flush the buffer; a response still in flight at redirect time is dropped on arrival.
module fetch_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
    parameter int BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc
);
    localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {REQ, WAIT, DROP} state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] pc, req_pc;
    logic [DATA_WIDTH-1:0] buf_pc   [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data [BUF_DEPTH];
    logic [PW-1:0]         head, tail;
    logic [CW-1:0]         count;
    logic                  accept, push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign imem_req_addr = pc;
    assign instr         = buf_data[head];
    assign instr_pc      = buf_pc[head];

    always_comb begin
        imem_req_valid = rst && state == REQ && count < CW'(BUF_DEPTH) && !redirect;
        instr_valid    = rst && count != '0 && !redirect;
        accept         = imem_req_valid && imem_req_ready;
        push           = state == WAIT && imem_rsp_valid && !redirect;
        pop            = instr_valid && instr_ready;
        state_d        = state;
        // a response landing in the redirect cycle closes the transaction, so no DROP is needed
        if (redirect)
            state_d = (state == WAIT && !imem_rsp_valid) ? DROP : REQ;
        else if (accept)
            state_d = WAIT;
        else if (state != REQ && imem_rsp_valid)
            state_d = REQ;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= REQ;
        else
            state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
            count  <= '0;
            head   <= '0;
            tail   <= '0;
        end else if (redirect) begin
            pc    <= redirect_target & ~DATA_WIDTH'(3);
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (accept) begin
                req_pc <= pc;
                pc     <= pc + DATA_WIDTH'(4);
            end
            if (push) begin
                buf_pc[tail]   <= req_pc;
                buf_data[tail] <= imem_rsp_data;
                tail           <= nxt(tail);
            end
            if (pop)
                head <= nxt(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_fetch_sequencer;
    localparam int DW = 32;
    localparam int DEPTH = 2;
    localparam logic [DW-1:0] RPC = 32'h0000_0000;

    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk, rst;
    logic          imem_req_valid, imem_req_ready;
    logic [DW-1:0] imem_req_addr;
    logic          imem_rsp_valid;
    logic [DW-1:0] imem_rsp_data;
    logic          redirect;
    logic [DW-1:0] redirect_target;
    logic          instr_valid, instr_ready;
    logic [DW-1:0] instr, instr_pc;

    int checks = 0;
    int failures = 0;
    int rsp_lat = 1;
    int cyc = 0;

    // event logs
    logic [DW-1:0] acc_a[$], pop_pc[$], pop_d[$], rsp_q[$];
    int            acc_c[$], pop_c[$];

    // model state and per-cycle expectations
    ent_t          m_q[$];
    logic [DW-1:0] m_pc, m_opc;
    logic          m_out, m_live;
    logic          e_req_valid, e_instr_valid;
    logic [DW-1:0] e_addr, e_pc, e_instr;

    fetch_sequencer #(.DATA_WIDTH(DW), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs;
        acc_a.delete(); acc_c.delete(); pop_pc.delete(); pop_d.delete(); pop_c.delete(); rsp_q.delete();
    endtask

    task automatic drain;
        imem_req_ready = 0;
        redirect = 0;
        repeat (8) tick;
        mid;
    endtask

    // imem: answers each accepted request rsp_lat cycles later (rsp_lat==0 picks 1..4)
    initial begin
        int cd;
        cd = 0;
        imem_rsp_valid = 0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready)
                cd = (rsp_lat == 0) ? int'($urandom_range(1, 4)) : rsp_lat;
            @(posedge clk);
            #1;
            imem_rsp_valid = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    imem_rsp_valid = 1;
                    imem_rsp_data = $urandom;
                    rsp_q.push_back(imem_rsp_data);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (imem_req_valid && imem_req_ready) begin
                acc_a.push_back(imem_req_addr);
                acc_c.push_back(cyc);
            end
            if (instr_valid && instr_ready) begin
                pop_pc.push_back(instr_pc);
                pop_d.push_back(instr);
                pop_c.push_back(cyc);
            end
        end
    end

    // model: a PC, at most one outstanding fetch (live or doomed), and a FIFO of fetched words
    initial begin
        m_pc = RPC; m_opc = '0; m_out = 0; m_live = 0;
        e_req_valid = 0; e_instr_valid = 0; e_addr = '0; e_pc = '0; e_instr = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                e_req_valid = 0;
                e_instr_valid = 0;
                m_pc = RPC;
                m_q.delete();
                m_out = 0;
            end else begin
                e_req_valid = !m_out && m_q.size() < DEPTH && !redirect;
                e_instr_valid = m_q.size() != 0 && !redirect;
                e_addr = m_pc;
                if (m_q.size() != 0) begin
                    e_pc = m_q[0].pc;
                    e_instr = m_q[0].d;
                end
                if (redirect) begin
                    m_q.delete();
                    m_pc = redirect_target & ~32'h3;
                    if (m_out && m_live && !imem_rsp_valid) m_live = 0;
                    else m_out = 0;
                end else begin
                    if (e_instr_valid && instr_ready) void'(m_q.pop_front());
                    if (m_out && imem_rsp_valid) begin
                        if (m_live) m_q.push_back('{m_opc, imem_rsp_data});
                        m_out = 0;
                    end
                    if (e_req_valid && imem_req_ready) begin
                        m_out = 1;
                        m_live = 1;
                        m_opc = m_pc;
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic test_reset;
        rst = 0; imem_req_ready = 1; instr_ready = 1; redirect = 0; redirect_target = '0;
        repeat (3) begin
            tick;
            mid;
            checks++;
            if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid);
            end
        end
        tick;
        rst = 1; imem_req_ready = 0;
        mid;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release req_valid=%b addr=%h instr_valid=%b expected 1 %h 0",
                     imem_req_valid, imem_req_addr, instr_valid, RPC);
        end
    endtask

    task automatic test_basic;
        tick;
        clear_logs();
        imem_req_ready = 1; instr_ready = 1; rsp_lat = 1;
        repeat (7) tick;
        tick;
        drain;
        checks++;
        if (acc_a.size() != 4 || pop_pc.size() != 4) begin
            failures++;
            $display("FAIL basic_counts accepts=%0d pops=%0d expected 4 4", acc_a.size(), pop_pc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (acc_a[i] !== 32'(4 * i) || pop_pc[i] !== 32'(4 * i) || pop_d[i] !== rsp_q[i]) begin
                    failures++;
                    $display("FAIL basic_word%0d addr=%h pc=%h instr=%h expected %h %h %h",
                             i, acc_a[i], pop_pc[i], pop_d[i], 32'(4 * i), 32'(4 * i), rsp_q[i]);
                end
                checks++;
                if (pop_c[i] - acc_c[i] != 2) begin
                    failures++;
                    $display("FAIL basic_latency%0d got=%0d expected 2", i, pop_c[i] - acc_c[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (acc_c[i] - acc_c[i-1] != 2) begin
                        failures++;
                        $display("FAIL basic_spacing%0d got=%0d expected 2", i, acc_c[i] - acc_c[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure;
        tick;
        clear_logs();
        instr_ready = 0; imem_req_ready = 1; rsp_lat = 2;
        repeat (9) tick;
        mid;
        checks++;
        if (acc_a.size() != DEPTH || imem_req_valid !== 1'b0 || instr_valid !== 1'b1 || pop_pc.size() != 0) begin
            failures++;
            $display("FAIL bp_full accepts=%0d req_valid=%b instr_valid=%b pops=%0d expected %0d 0 1 0",
                     acc_a.size(), imem_req_valid, instr_valid, pop_pc.size(), DEPTH);
        end
        tick;
        instr_ready = 1;
        repeat (11) tick;
        drain;
        checks++;
        if (pop_pc.size() != acc_a.size() || acc_a.size() < 4) begin
            failures++;
            $display("FAIL bp_counts pops=%0d accepts=%0d expected equal and >=4", pop_pc.size(), acc_a.size());
        end else begin
            for (int i = 0; i < pop_pc.size(); i++) begin
                checks++;
                if (pop_pc[i] !== acc_a[i] || pop_pc[i] !== acc_a[0] + 32'(4 * i) || pop_d[i] !== rsp_q[i]) begin
                    failures++;
                    $display("FAIL bp_word%0d pc=%h instr=%h expected %h %h",
                             i, pop_pc[i], pop_d[i], acc_a[0] + 32'(4 * i), rsp_q[i]);
                end
            end
        end
    endtask

    task automatic test_redirect_wait;
        tick;
        clear_logs();
        imem_req_ready = 1; instr_ready = 1; rsp_lat = 4;
        tick;
        redirect = 1; redirect_target = 32'h100;
        mid;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rw_redirect_cycle req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid);
        end
        tick;
        redirect = 0;
        repeat (12) tick;
        drain;
        checks++;
        if (acc_a.size() != 3 || pop_pc.size() != 2 || rsp_q.size() != 3) begin
            failures++;
            $display("FAIL rw_counts accepts=%0d pops=%0d rsps=%0d expected 3 2 3", acc_a.size(), pop_pc.size(), rsp_q.size());
        end else begin
            checks++;
            if (acc_a[1] !== 32'h100 || pop_pc[0] !== 32'h100 || pop_d[0] !== rsp_q[1]) begin
                failures++;
                $display("FAIL rw_first addr=%h pc=%h instr=%h expected 100 100 %h", acc_a[1], pop_pc[0], pop_d[0], rsp_q[1]);
            end
            checks++;
            if (pop_pc[1] !== 32'h104 || pop_d[1] !== rsp_q[2]) begin
                failures++;
                $display("FAIL rw_second pc=%h instr=%h expected 104 %h", pop_pc[1], pop_d[1], rsp_q[2]);
            end
        end
    endtask

    task automatic test_redirect_buffered;
        tick;
        clear_logs();
        instr_ready = 0; imem_req_ready = 1; rsp_lat = 1;
        repeat (5) tick;
        tick;
        imem_req_ready = 0;
        tick;
        redirect = 1; redirect_target = 32'h203;
        mid;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rb_redirect_cycle instr_valid=%b req_valid=%b expected 0 0", instr_valid, imem_req_valid);
        end
        tick;
        redirect = 0;
        mid;
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            failures++;
            $display("FAIL rb_after instr_valid=%b req_valid=%b addr=%h expected 0 1 200", instr_valid, imem_req_valid, imem_req_addr);
        end
        tick;
        imem_req_ready = 1; instr_ready = 1;
        repeat (6) tick;
        drain;
        checks++;
        if (acc_a.size() < 3 || pop_pc.size() != acc_a.size() - 2 || pop_pc[0] !== 32'h200) begin
            failures++;
            $display("FAIL rb_refill accepts=%0d pops=%0d first_pc=%h expected pops=accepts-2 first 200",
                     acc_a.size(), pop_pc.size(), pop_pc.size() ? pop_pc[0] : 32'hx);
        end
    endtask

    task automatic test_req_stall;
        logic [DW-1:0] a0;
        tick;
        clear_logs();
        instr_ready = 1; rsp_lat = 1; imem_req_ready = 0;
        mid;
        a0 = e_addr;
        repeat (3) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a0) begin
                failures++;
                $display("FAIL stall_hold req_valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, a0);
            end
            tick;
            mid;
        end
        tick;
        imem_req_ready = 1;
        mid;
        checks++;
        if (acc_a.size() != 1 || acc_a[0] !== a0) begin
            failures++;
            $display("FAIL stall_accept accepts=%0d addr=%h expected 1 %h", acc_a.size(), acc_a.size() ? acc_a[0] : 32'hx, a0);
        end
        tick;
        imem_req_ready = 0;
        tick;
        mid;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== a0 + 32'd4) begin
            failures++;
            $display("FAIL stall_advance req_valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, a0 + 32'd4);
        end
        drain;
    endtask

    task automatic test_wrap_and_reset;
        tick;
        clear_logs();
        redirect = 1; redirect_target = 32'hFFFF_FFFC; imem_req_ready = 1; instr_ready = 1; rsp_lat = 1;
        tick;
        redirect = 0;
        repeat (5) tick;
        drain;
        checks++;
        if (acc_a.size() < 2 || pop_pc.size() < 2 || acc_a[0] !== 32'hFFFF_FFFC || acc_a[1] !== 32'h0 ||
            pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0) begin
            failures++;
            $display("FAIL wrap accepts=%0d pops=%0d expected fetch FFFFFFFC then 00000000", acc_a.size(), pop_pc.size());
        end
        tick;
        clear_logs();
        rsp_lat = 3; imem_req_ready = 1;
        tick;
        rst = 0; imem_req_ready = 0;
        mid;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs req_valid=%b instr_valid=%b expected 0 0", imem_req_valid, instr_valid);
        end
        tick;
        rst = 1;
        repeat (5) begin
            mid;
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL midreset_idle req_valid=%b addr=%h instr_valid=%b expected 1 %h 0",
                         imem_req_valid, imem_req_addr, instr_valid, RPC);
            end
            tick;
        end
        checks++;
        if (rsp_q.size() != 1) begin
            failures++;
            $display("FAIL midreset_late_rsp rsps=%0d expected 1", rsp_q.size());
        end
        clear_logs();
        imem_req_ready = 1; rsp_lat = 1;
        repeat (4) tick;
        drain;
        checks++;
        if (pop_pc.size() == 0 || pop_pc[0] !== RPC || pop_d[0] !== rsp_q[0]) begin
            failures++;
            $display("FAIL midreset_refetch pops=%0d first_pc=%h expected >0 %h", pop_pc.size(),
                     pop_pc.size() ? pop_pc[0] : 32'hx, RPC);
        end
    endtask

    task automatic test_random;
        rsp_lat = 0;
        for (int n = 0; n < 1500; n++) begin
            tick;
            imem_req_ready = ($urandom_range(0, 9) < 7);
            instr_ready = ($urandom_range(0, 9) < 6);
            redirect = !redirect && ($urandom_range(0, 19) == 0);
            redirect_target = $urandom;
            mid;
            checks++;
            if (imem_req_valid !== e_req_valid || instr_valid !== e_instr_valid) begin
                failures++;
                $display("FAIL rand_valid cyc=%0d req_valid=%b instr_valid=%b expected %b %b",
                         cyc, imem_req_valid, instr_valid, e_req_valid, e_instr_valid);
            end
            if (e_req_valid) begin
                checks++;
                if (imem_req_addr !== e_addr) begin
                    failures++;
                    $display("FAIL rand_addr cyc=%0d got=%h expected %h", cyc, imem_req_addr, e_addr);
                end
            end
            if (e_instr_valid) begin
                checks++;
                if (instr_pc !== e_pc || instr !== e_instr) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d pc=%h instr=%h expected %h %h", cyc, instr_pc, instr, e_pc, e_instr);
                end
            end
        end
        drain;
    endtask

    initial begin
        rst = 0; imem_req_ready = 0; instr_ready = 0; redirect = 0; redirect_target = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_redirect_wait();
        test_redirect_buffered();
        test_req_stall();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
